// File: rtl/shift_pkg.sv
// shift_pkg: shared shift-type codes, sequencer state enum and word width for the register-amount shift path
package shift_pkg;
  localparam int WORD_W = 32;
  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} seq_state_t;
endpackage

// File: rtl/shift_step.sv
// shift_step: combinational shift of val by k (0..2**STEP_LOG2) for type typ; res is the shifted word, cout the last bit shifted out (ROR: new bit31)
module shift_step
  import shift_pkg::*;
#(
  parameter int STEP_LOG2 = 2
) (
  input  logic [WORD_W-1:0]  val,
  input  logic [1:0]         typ,
  input  logic [STEP_LOG2:0] k,
  output logic [WORD_W-1:0]  res,
  output logic               cout
);
  logic [WORD_W:0] l, r;
  logic signed [WORD_W:0] a;
  logic [WORD_W-1:0] ror;
  always_comb begin
    l = {1'b0, val} << k;
    a = $signed({val, 1'b0}) >>> k;
    r = typ == SH_ASR ? unsigned'(a) : {val, 1'b0} >> k;
    ror = (val >> k) | (val << (6'(WORD_W) - 6'(k)));
    res = typ == SH_LSL ? l[WORD_W-1:0] : typ == SH_ROR ? ror : r[WORD_W:1];
    cout = typ == SH_LSL ? l[WORD_W] : typ == SH_ROR ? ror[WORD_W-1] : r[0];
  end
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle register-amount shifter (start/shift_type/val_rm/shift_amt/carry_in in; busy/done/result and, with SHIFT_SEQ_CARRY_EN, carry_out out)
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int STEP_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        shift_type,
  input  logic [WORD_W-1:0] val_rm,
  input  logic [7:0]        shift_amt,
  input  logic              carry_in,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] result
`ifdef SHIFT_SEQ_CARRY_EN
  ,
  output logic              carry_out
`endif
);
  localparam int STEP = 1 << STEP_LOG2;
  localparam int KW = STEP_LOG2 + 1;
  seq_state_t state;
  logic [4:0] rem;
  logic [1:0] typ;
  logic [WORD_W-1:0] work, st_val, sc_val;
  logic [KW-1:0] k;
  logic st_c, accept, big, iter;
  shift_step #(.STEP_LOG2(STEP_LOG2)) u_step (.val(work), .typ(typ), .k(k), .res(st_val), .cout(st_c));
`ifdef SHIFT_SEQ_CARRY_EN
  logic carry, sc_c;
  always_comb begin
    sc_c = shift_amt == 8'd0 ? carry_in
         : shift_type == SH_ROR || shift_type == SH_ASR ? val_rm[WORD_W-1]
         : shift_amt == 8'd32 ? (shift_type == SH_LSL ? val_rm[0] : val_rm[WORD_W-1])
         : 1'b0;
  end
  assign carry_out = carry;
`else
  logic unused_carry;
  assign unused_carry = ^{carry_in, st_c};
`endif
  always_comb begin
    accept = start && state != SHIFT;
    big = shift_amt[7:5] != 3'd0;
    iter = shift_amt[4:0] != 5'd0 && (shift_type == SH_ROR || !big);
    sc_val = shift_amt == 8'd0 || shift_type == SH_ROR ? val_rm
           : shift_type == SH_ASR ? {WORD_W{val_rm[WORD_W-1]}} : '0;
    k = KW'(rem > 5'(STEP) ? 5'(STEP) : rem);
    busy = state != IDLE;
    done = state == DONE;
    result = work;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rem <= '0;
      typ <= SH_LSL;
      work <= '0;
`ifdef SHIFT_SEQ_CARRY_EN
      carry <= 1'b0;
`endif
    end else if (accept) begin
      state <= iter ? SHIFT : DONE;
      rem <= iter ? shift_amt[4:0] : 5'd0;
      typ <= shift_type;
      work <= iter ? val_rm : sc_val;
`ifdef SHIFT_SEQ_CARRY_EN
      carry <= iter ? carry_in : sc_c;
`endif
    end else if (state == SHIFT) begin
      state <= rem == 5'(k) ? DONE : SHIFT;
      rem <= rem - 5'(k);
      work <= st_val;
`ifdef SHIFT_SEQ_CARRY_EN
      carry <= st_c;
`endif
    end else if (state == DONE) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: table-driven check of shift_sequencer results, latency, done pulse, back-to-back and mid-shift reset
module tb_shift_sequencer;
  import shift_pkg::*;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, carry_in = 1'b0;
  logic [1:0] shift_type = SH_LSL;
  logic [31:0] val_rm = '0;
  logic [7:0] shift_amt = '0;
  logic busy, done;
  logic [31:0] result;
`ifdef SHIFT_SEQ_CARRY_EN
  logic carry_out;
`endif
  int errors = 0, checks = 0;
  shift_sequencer #(.STEP_LOG2(2)) dut (
    .clk(clk), .rst(rst), .start(start), .shift_type(shift_type), .val_rm(val_rm),
    .shift_amt(shift_amt), .carry_in(carry_in), .busy(busy), .done(done), .result(result)
`ifdef SHIFT_SEQ_CARRY_EN
    , .carry_out(carry_out)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0]  typ;
    logic [31:0] val;
    logic [7:0]  amt;
    logic        cin;
    logic [31:0] exp_res;
    logic        exp_c;
    int          lat;
  } vec_t;
  vec_t vecs[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  task automatic chk_carry(input string name, input logic exp);
`ifdef SHIFT_SEQ_CARRY_EN
    chk(name, {31'd0, carry_out}, {31'd0, exp});
`endif
  endtask
  task automatic run_job(input vec_t v, input string tag);
    int n;
    @(negedge clk);
    shift_type = v.typ; val_rm = v.val; shift_amt = v.amt; carry_in = v.cin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(v.lat));
    chk({tag, " result"}, result, v.exp_res);
    chk_carry({tag, " carry"}, v.exp_c);
    @(negedge clk);
    chk({tag, " done pulse"}, {31'd0, done}, 32'd0);
    chk({tag, " busy after"}, {31'd0, busy}, 32'd0);
  endtask
  initial begin
    vecs.push_back('{SH_LSL, 32'h0000_0001, 8'd5,   1'b0, 32'h0000_0020, 1'b0, 3});
    vecs.push_back('{SH_ROR, 32'h0000_00F1, 8'd4,   1'b0, 32'h1000_000F, 1'b0, 2});
    vecs.push_back('{SH_ROR, 32'h0000_00F1, 8'd36,  1'b1, 32'h1000_000F, 1'b0, 2});
    vecs.push_back('{SH_ASR, 32'h8000_0000, 8'd40,  1'b0, 32'hFFFF_FFFF, 1'b1, 1});
    vecs.push_back('{SH_LSR, 32'h8000_0000, 8'd32,  1'b0, 32'h0000_0000, 1'b1, 1});
    vecs.push_back('{SH_LSL, 32'h1234_5678, 8'd0,   1'b1, 32'h1234_5678, 1'b1, 1});
    vecs.push_back('{SH_LSL, 32'h8000_0001, 8'd32,  1'b0, 32'h0000_0000, 1'b1, 1});
    vecs.push_back('{SH_LSL, 32'hFFFF_FFFF, 8'd33,  1'b1, 32'h0000_0000, 1'b0, 1});
    vecs.push_back('{SH_LSR, 32'hFFFF_FFFF, 8'd40,  1'b1, 32'h0000_0000, 1'b0, 1});
    vecs.push_back('{SH_LSR, 32'hF000_0000, 8'd31,  1'b0, 32'h0000_0001, 1'b1, 9});
    vecs.push_back('{SH_ASR, 32'h8000_0000, 8'd1,   1'b1, 32'hC000_0000, 1'b0, 2});
    vecs.push_back('{SH_ASR, 32'h7FFF_FFFF, 8'd200, 1'b1, 32'h0000_0000, 1'b0, 1});
    vecs.push_back('{SH_ROR, 32'h8000_0000, 8'd32,  1'b0, 32'h8000_0000, 1'b1, 1});
    vecs.push_back('{SH_ROR, 32'h0000_0001, 8'd1,   1'b0, 32'h8000_0000, 1'b1, 2});
    vecs.push_back('{SH_ROR, 32'hAAAA_5555, 8'd0,   1'b0, 32'hAAAA_5555, 1'b0, 1});
    vecs.push_back('{SH_LSR, 32'h0000_00FF, 8'd8,   1'b0, 32'h0000_0000, 1'b1, 3});
    vecs.push_back('{SH_LSL, 32'h0000_000F, 8'd31,  1'b0, 32'h8000_0000, 1'b1, 9});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    chk_carry("reset carry", 1'b0);
    foreach (vecs[i]) run_job(vecs[i], $sformatf("vec%0d", i));
    // back-to-back: request held through SHIFT must be ignored, then taken in DONE
    @(negedge clk);
    shift_type = SH_LSL; val_rm = 32'h1; shift_amt = 8'd5; start = 1'b1;
    @(negedge clk);
    shift_type = SH_ROR; val_rm = 32'hF1; shift_amt = 8'd4;
    chk("b2b c1 done", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("b2b c2 done", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("b2b A done", {31'd0, done}, 32'd1);
    chk("b2b A result", result, 32'h0000_0020);
    @(negedge clk);
    chk("b2b c4 done", {31'd0, done}, 32'd0);
    chk("b2b c4 busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    chk("b2b B done", {31'd0, done}, 32'd1);
    chk("b2b B result", result, 32'h1000_000F);
    chk_carry("b2b B carry", 1'b0);
    @(negedge clk);
    chk("b2b c6 done", {31'd0, done}, 32'd0);
    chk("b2b c6 busy", {31'd0, busy}, 32'd0);
    // reset during the third SHIFT cycle of a 31-bit LSL
    @(negedge clk);
    shift_type = SH_LSL; val_rm = 32'hF; shift_amt = 8'd31; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst result", result, 32'd0);
    chk_carry("rst carry", 1'b0);
    run_job(vecs[vecs.size()-1], "post-reset");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
